// File: rtl/cpc_bus_pkg.sv
// Shared definitions for the CPC expansion-bus initiator: bus-cycle state
// encoding, command type codes and default address constants.
package cpc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TWIO = 3'd3,
    ST_TW   = 3'd4,
    ST_T3   = 3'd5,
    ST_RSP  = 3'd6
  } bus_state_t;

  localparam logic CMD_IO_WR  = 1'b0;
  localparam logic CMD_ROM_RD = 1'b1;

  localparam logic [15:0] DEF_ROM_BASE       = 16'hC000;
  localparam logic [7:0]  DEF_IO_HI_BYTE     = 8'hDF;
  localparam int          DEF_TIMEOUT_CYCLES = 255;

  // Address inside the upper-ROM window for a 14-bit offset.
  function automatic logic [15:0] rom_addr(input logic [15:0] base, input logic [13:0] offset);
    return base | {2'b00, offset};
  endfunction

endpackage

// File: rtl/cpc_wait_counter.sv
// Counts consecutive wait-state cycles and flags the cycle on which the
// configured limit is reached. Only used when CPC_BUS_TIMEOUT_EN is defined.
module cpc_wait_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_b,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_reg;

  // Count wait cycles; cleared at the start of every bus cycle.
  always_ff @(posedge clk) begin
    if (!reset_b || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // The current wait cycle is the TIMEOUT_CYCLES-th one.
  assign expired = enable && (count_reg == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cpc_rom_bus_master.sv
// Z80-style bus initiator for the CPC edge connector: issues ROM-select I/O
// writes and upper-ROM memory reads toward an expansion board under test.
// Optional macro CPC_BUS_TIMEOUT_EN adds a wait-state timeout abort.
module cpc_rom_bus_master
  import cpc_bus_pkg::*;
#(
  parameter logic [7:0]  IO_HI_BYTE     = DEF_IO_HI_BYTE,
  parameter logic [15:0] ROM_BASE       = DEF_ROM_BASE,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        CLK,
  input  logic        RESET_B,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_type,
  input  logic [13:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_romdis,
  output logic        rsp_err,
  output logic [7:0]  last_rom,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        MREQ_B,
  output logic        IOREQ_B,
  output logic        RD_B,
  output logic        WR_B,
  output logic        ROMEN_B,
  input  logic        READY,
  input  logic        ROMDIS
);

  bus_state_t  state_reg, state_next;
  logic        type_reg;
  logic [7:0]  data_reg;
  logic [15:0] a_reg;
  logic [7:0]  d_out_reg;
  logic        d_oe_reg;
  logic [7:0]  rsp_data_reg;
  logic        rsp_romdis_reg;
  logic [7:0]  last_rom_reg;
  logic        bus_active;
  logic        timeout_hit;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic plus handshake and strobe-window decode.
  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    bus_active = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = RESET_B;
        if (cmd_valid && RESET_B) state_next = ST_T1;
      end
      ST_T1: state_next = ST_T2;
      ST_T2: begin
        bus_active = 1'b1;
        if (type_reg == CMD_IO_WR) state_next = ST_TWIO;
        else if (READY)            state_next = ST_T3;
        else                       state_next = ST_TW;
      end
      ST_TWIO: begin
        bus_active = 1'b1;
        state_next = READY ? ST_T3 : ST_TW;
      end
      ST_TW: begin
        bus_active = 1'b1;
        if (timeout_hit) state_next = ST_RSP;
        else if (READY)  state_next = ST_T3;
      end
      ST_T3: begin
        bus_active = 1'b1;
        state_next = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Strobes are asserted from T2 through T3 for the registered cycle type.
  assign MREQ_B  = !(bus_active && (type_reg == CMD_ROM_RD));
  assign RD_B    = !(bus_active && (type_reg == CMD_ROM_RD));
  assign ROMEN_B = !(bus_active && (type_reg == CMD_ROM_RD));
  assign IOREQ_B = !(bus_active && (type_reg == CMD_IO_WR));
  assign WR_B    = !(bus_active && (type_reg == CMD_IO_WR));

  // Command capture at accept, bus drive, and response capture at end of T3.
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      type_reg       <= CMD_IO_WR;
      data_reg       <= 8'h00;
      a_reg          <= 16'h0000;
      d_out_reg      <= 8'h00;
      d_oe_reg       <= 1'b0;
      rsp_data_reg   <= 8'h00;
      rsp_romdis_reg <= 1'b0;
      last_rom_reg   <= 8'h00;
    end else begin
      if (state_reg == ST_IDLE && cmd_valid) begin
        type_reg <= cmd_type;
        data_reg <= cmd_data;
        if (cmd_type == CMD_ROM_RD) begin
          a_reg    <= rom_addr(ROM_BASE, cmd_addr);
          d_oe_reg <= 1'b0;
        end else begin
          a_reg     <= {IO_HI_BYTE, 8'h00};
          d_out_reg <= cmd_data;
          d_oe_reg  <= 1'b1;
        end
      end
      if (state_reg == ST_T3) begin
        rsp_data_reg   <= (type_reg == CMD_ROM_RD) ? D_in : 8'h00;
        rsp_romdis_reg <= ROMDIS;
        d_oe_reg       <= 1'b0;
        if (type_reg == CMD_IO_WR) last_rom_reg <= data_reg;
      end
      if (timeout_hit) begin
        rsp_data_reg   <= 8'hFF;
        rsp_romdis_reg <= 1'b0;
        d_oe_reg       <= 1'b0;
      end
    end
  end

`ifdef CPC_BUS_TIMEOUT_EN
  logic rsp_err_reg;

  cpc_wait_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk     (CLK),
    .reset_b (RESET_B),
    .clear   (state_reg == ST_T1),
    .enable  (state_reg == ST_TW),
    .expired (timeout_hit)
  );

  // Error flag: set by an aborted cycle, cleared by a normal completion.
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      rsp_err_reg <= 1'b0;
    end else if (state_reg == ST_T3) begin
      rsp_err_reg <= 1'b0;
    end else if (timeout_hit) begin
      rsp_err_reg <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_reg;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  assign A          = a_reg;
  assign D_out      = d_out_reg;
  assign D_oe       = d_oe_reg;
  assign rsp_data   = rsp_data_reg;
  assign rsp_romdis = rsp_romdis_reg;
  assign last_rom   = last_rom_reg;

endmodule

// File: doc/cpc_rom_bus_master.md
Name: cpc_rom_bus_master

Overview:
- Synthesizable Z80-style expansion-bus initiator for the CPC edge connector.
- Issues the two bus-cycle types an upper-ROM board responds to:
  - I/O write of a ROM number to the ROM-select port (A13 low).
  - Memory read from the upper-ROM window &C000-&FFFF with ROMEN_B asserted.
- Used in the FPGA board-tester fixture to exercise ROM expansion boards. Samples returned data and ROMDIS.
- Simple valid/ready command and response interface toward the test controller.

Parameters:
- IO_HI_BYTE, 8'hDF, high address byte driven during ROM-select I/O writes (A13 must be 0).
- ROM_BASE, 16'hC000, base of the upper-ROM window; read address = ROM_BASE | cmd_addr.
- TIMEOUT_CYCLES, 255, maximum READY-low cycles before abort (only with CPC_BUS_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock, one bus T-state per cycle
- RESET_B  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_type  in  1  0 = ROM-select I/O write, 1 = ROM read
- cmd_addr  in  14  offset within the 16K ROM window (reads only)
- cmd_data  in  8  ROM number (writes only)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_data  out  8  read data; 0 for writes
- rsp_romdis  out  1  ROMDIS sampled at T3
- rsp_err  out  1  timeout abort; tied 0 without the macro
- last_rom  out  8  ROM number of the last completed select write
- A  out  16  address bus
- D_out  out  8  data to bus
- D_oe  out  1  data-bus output enable
- D_in  in  8  data from bus
- MREQ_B, IOREQ_B, RD_B, WR_B, ROMEN_B  out  1 each  active-low strobes
- READY  in  1  wait request, low = wait
- ROMDIS  in  1  ROM-disable from the responder

Behaviour:
- Reset values:
  - A = 0, D_out = 0, D_oe = 0.
  - All _B strobes = 1.
  - rsp_valid = 0, rsp_data = 0, rsp_romdis = 0, rsp_err = 0, last_rom = 0.
  - State = IDLE.
- cmd_ready = (state==IDLE) & RESET_B. It stays low while rsp_valid is held.
- States: IDLE -> T1 -> T2 -> [TWIO] -> TW* -> T3 -> RSP -> IDLE.
- T1 (first cycle after accept):
  - Read: A = ROM_BASE | cmd_addr.
  - Write: A = {IO_HI_BYTE, 8'h00}, D_out = cmd_data, D_oe = 1.
  - Strobes stay high.
- T2:
  - Read: MREQ_B = 0, RD_B = 0, ROMEN_B = 0.
  - Write: IOREQ_B = 0, WR_B = 0.
- TWIO: mandatory single I/O wait state, write cycles only.
- READY is sampled at the end of T2 (or TWIO). If READY = 0, go to TW and stay there while READY = 0. Strobes and A/D are held unchanged.
- T3:
  - Strobes still asserted.
  - At the end of T3, capture D_in into rsp_data (reads) and ROMDIS into rsp_romdis.
  - Writes: last_rom <= cmd_data at the end of T3.
- RSP:
  - All strobes high, D_oe = 0, A holds its value, rsp_valid = 1.
  - Stay in RSP until rsp_ready; return to IDLE the following cycle.
- Latency, accept edge to rsp_valid high: read 4 cycles, write 5 cycles, plus the READY-low cycle count.
- Reset mid-operation: the next edge forces reset values. The in-flight command is dropped with no response, and last_rom is cleared.
- cmd_valid asserted outside IDLE is ignored. Command fields are registered at accept; later changes have no effect.

Optional Feature:
- CPC_BUS_TIMEOUT_EN defined:
  - A counter of width ceil(log2(TIMEOUT_CYCLES+1)) counts consecutive TW cycles.
  - When the count reaches TIMEOUT_CYCLES, deassert strobes and go to RSP with rsp_err = 1, rsp_data = 8'hFF.
  - last_rom is not updated on an aborted write.
  - The counter clears at T1.
- Undefined: TW waits indefinitely and rsp_err is constant 0.

Decomposition:
- Package cpc_bus_pkg holds:
  - the bus-state enum;
  - CMD_IO_WR = 1'b0 and CMD_ROM_RD = 1'b1;
  - default ROM_BASE and IO_HI_BYTE constants.
- One natural sub-module, cpc_wait_counter: the timeout counter, instantiated only under CPC_BUS_TIMEOUT_EN.

Test Plan:
- Reset held 3 cycles, then released -> strobes all 1, D_oe = 0, A = 0, rsp_valid = 0, cmd_ready = 1.
- Write ROM 5, READY = 1 -> A = 16'hDF00, D_out = 8'h05 and D_oe = 1 from T1 to T3; IOREQ_B/WR_B low exactly 3 cycles; rsp_valid 5 cycles after accept; last_rom = 5.
- Read cmd_addr = 14'h0123, responder drives 8'hA5 with ROMDIS = 1 -> A = 16'hC123; MREQ_B/RD_B/ROMEN_B low exactly 2 cycles; rsp_data = 8'hA5, rsp_romdis = 1 at cycle 4.
- Read with READY low for 3 cycles from T2 -> strobes low 5 cycles; rsp_valid at cycle 7. Hold rsp_ready = 0 for 4 cycles -> rsp_valid and data stable, cmd_ready = 0 throughout.
- RESET_B low during T2 of a write -> next cycle all strobes 1, D_oe = 0, no rsp_valid, last_rom = 0.
- CPC_BUS_TIMEOUT_EN with READY stuck low -> after 255 TW cycles: rsp_err = 1, rsp_data = 8'hFF, last_rom unchanged; the next command completes normally.
